controller_sequencer: RTL

Controller-sequencer for the SAP-1 datapath. Advances a six-phase T-state ring and decodes the instruction-register opcode into the 12-bit control word. That word drives every bus stage:
- program counter (Cp, Ep)
- MAR, RAM and IR
- accumulator, adder/subtracter, B and output registers

It sits directly upstream of the program counter. It also stops the machine on HLT.

---
 rtl/sap1_pkg.sv | 42 ++++
 rtl/controller_sequencer_if.sv | 34 +++
 rtl/controller_sequencer_ring_counter.sv | 54 +++++
 rtl/controller_sequencer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 controller-sequencer: opcodes, the
// 12-bit control word layout, the idle word, T-state indices and the
// run/halt mode encoding used by the ring counter.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Field order matches the bus order Cp (MSB) ... Lo_n (LSB).
  typedef struct packed {
    logic cp;
    logic ep;
    logic lm_n;
    logic ce_n;
    logic li_n;
    logic ei_n;
    logic la_n;
    logic ea;
    logic su;
    logic eu;
    logic lb_n;
    logic lo_n;
  } con_t;

  localparam con_t CON_IDLE = con_t'(12'h3E3);

  localparam int unsigned T1_IDX = 0;
  localparam int unsigned T2_IDX = 1;
  localparam int unsigned T3_IDX = 2;
  localparam int unsigned T4_IDX = 3;
  localparam int unsigned T5_IDX = 4;
  localparam int unsigned T6_IDX = 5;

  typedef enum logic {
    MODE_RUN    = 1'b0,
    MODE_HALTED = 1'b1
  } mode_t;

endpackage

// File: rtl/controller_sequencer_if.sv
// Bus between the controller-sequencer and the SAP-1 datapath: the IR
// opcode going in, the control word, halt flag and T-state debug coming out.
interface controller_sequencer_if #(
  parameter int OPCODE_WIDTH = 4,
  parameter int T_STATES     = 6
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    Cp;
  logic                    Ep;
  logic                    Lm_n;
  logic                    CE_n;
  logic                    Li_n;
  logic                    Ei_n;
  logic                    La_n;
  logic                    Ea;
  logic                    Su;
  logic                    Eu;
  logic                    Lb_n;
  logic                    Lo_n;
  logic                    HLT;
  logic [T_STATES-1:0]     t_state;

  modport master (
    input  opcode,
    output Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n,
    output HLT, t_state
  );

  modport slave (
    output opcode,
    input  Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n,
    input  HLT, t_state
  );
endinterface

// File: rtl/controller_sequencer_ring_counter.sv
// One-hot T-state ring with a run/halted mode. Clears asynchronously to
// T1/run. A halt request freezes the ring and reports all-zero phases;
// an early-return request jumps straight back to T1.
module ring_counter
  import sap1_pkg::*;
#(
  parameter int T_STATES = 6
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_halt,
  input  logic                i_early,
  output logic [T_STATES-1:0] o_ring,
  output logic                o_halted
);

  localparam logic [T_STATES-1:0] RING_T1 = {{(T_STATES-1){1'b0}}, 1'b1};

  logic [T_STATES-1:0] r_ring;
  mode_t               r_mode;

  // Phase/mode state: rotate each cycle, enter HALTED on request, stay there until clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ring <= RING_T1;
      r_mode <= MODE_RUN;
    end else begin
      case (r_mode)
        MODE_RUN: begin
          if (i_halt) begin
            r_mode <= MODE_HALTED;
            r_ring <= r_ring;
          end else if (i_early) begin
            r_ring <= RING_T1;
          end else begin
            r_ring <= {r_ring[T_STATES-2:0], r_ring[T_STATES-1]};
          end
        end
        MODE_HALTED: begin
          r_mode <= MODE_HALTED;
          r_ring <= r_ring;
        end
        default: begin
          r_mode <= MODE_RUN;
          r_ring <= RING_T1;
        end
      endcase
    end
  end

  assign o_halted = (r_mode == MODE_HALTED);
  assign o_ring   = o_halted ? {T_STATES{1'b0}} : r_ring;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: decodes the current T-state and IR opcode
// into the 12-bit control word and stops the machine on HLT.
// Optional feature macro: SAP1_VARIABLE_CYCLE_EN skips idle trailing phases
// (LDA ends after T5, OUT/NOP after T4).
module controller_sequencer
  import sap1_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int T_STATES     = 6
) (
  input  logic                    CLK_n,
  input  logic                    CLR_n,
  controller_sequencer_if.master  bus
);

  logic [T_STATES-1:0]     w_ring;
  logic                    w_halted;
  logic                    w_halt_req;
  logic                    w_early;
  logic                    w_hlt;
  logic [OPCODE_WIDTH-1:0] w_opcode;
  con_t                    w_con;

  assign w_opcode = bus.opcode;

  ring_counter #(.T_STATES(T_STATES)) u_ring (
    .i_clk    (CLK_n),
    .i_rst_n  (CLR_n),
    .i_halt   (w_halt_req),
    .i_early  (w_early),
    .o_ring   (w_ring),
    .o_halted (w_halted)
  );

  // Control word decode from phase and opcode; idle while clear is asserted.
  always_comb begin
    w_con      = CON_IDLE;
    w_hlt      = 1'b0;
    w_halt_req = 1'b0;
    w_early    = 1'b0;
    if (!CLR_n) begin
      w_con = CON_IDLE;
    end else if (w_halted) begin
      w_hlt = 1'b1;
    end else if (w_ring[T1_IDX]) begin
      w_con.ep   = 1'b1;
      w_con.lm_n = 1'b0;
    end else if (w_ring[T2_IDX]) begin
      w_con.cp = 1'b1;
    end else if (w_ring[T3_IDX]) begin
      w_con.ce_n = 1'b0;
      w_con.li_n = 1'b0;
    end else if (w_ring[T4_IDX]) begin
      case (w_opcode)
        OP_LDA, OP_ADD, OP_SUB: begin
          w_con.ei_n = 1'b0;
          w_con.lm_n = 1'b0;
        end
        OP_OUT: begin
          w_con.ea   = 1'b1;
          w_con.lo_n = 1'b0;
`ifdef SAP1_VARIABLE_CYCLE_EN
          w_early = 1'b1;
`else
          w_early = 1'b0;
`endif
        end
        OP_HLT: begin
          w_hlt      = 1'b1;
          w_halt_req = 1'b1;
        end
        default: begin
`ifdef SAP1_VARIABLE_CYCLE_EN
          w_early = 1'b1;
`else
          w_early = 1'b0;
`endif
        end
      endcase
    end else if (w_ring[T5_IDX]) begin
      case (w_opcode)
        OP_LDA: begin
          w_con.ce_n = 1'b0;
          w_con.la_n = 1'b0;
`ifdef SAP1_VARIABLE_CYCLE_EN
          w_early = 1'b1;
`else
          w_early = 1'b0;
`endif
        end
        OP_ADD, OP_SUB: begin
          w_con.ce_n = 1'b0;
          w_con.lb_n = 1'b0;
        end
        default: w_con = CON_IDLE;
      endcase
    end else if (w_ring[T6_IDX]) begin
      case (w_opcode)
        OP_ADD: begin
          w_con.eu   = 1'b1;
          w_con.la_n = 1'b0;
        end
        OP_SUB: begin
          w_con.eu   = 1'b1;
          w_con.su   = 1'b1;
          w_con.la_n = 1'b0;
        end
        default: w_con = CON_IDLE;
      endcase
    end else begin
      w_con = CON_IDLE;
    end
  end

  assign bus.Cp      = w_con.cp;
  assign bus.Ep      = w_con.ep;
  assign bus.Lm_n    = w_con.lm_n;
  assign bus.CE_n    = w_con.ce_n;
  assign bus.Li_n    = w_con.li_n;
  assign bus.Ei_n    = w_con.ei_n;
  assign bus.La_n    = w_con.la_n;
  assign bus.Ea      = w_con.ea;
  assign bus.Su      = w_con.su;
  assign bus.Eu      = w_con.eu;
  assign bus.Lb_n    = w_con.lb_n;
  assign bus.Lo_n    = w_con.lo_n;
  assign bus.HLT     = w_hlt;
  assign bus.t_state = CLR_n ? w_ring : {T_STATES{1'b0}};

endmodule
